// File: rtl/bel_cmul_arb_if.sv
// rtl/bel_cmul_arb_if.sv - requester/response handshake bundle for bel_cmul_arb
//
// Purpose: groups the two-requester operand and result handshakes that sit
// in front of one shared bel_cmul complex multiplier.
// Signals:
//   req_valid[n]  requester n presents an operation
//   req_ready[n]  operation of requester n accepted this cycle (one-hot)
//   req0_op       {a_re,a_im,b_re,b_im} of requester 0, signed Q1.(W-1)
//   req1_op       same packing, requester 1
//   rsp_valid[n]  result on rsp_re/rsp_im belongs to requester n (one-hot)
//   rsp_ready[n]  requester n accepts its result
//   rsp_re/im     multiplier result
// Modports: master = requester side, slave = arbiter side.
interface bel_cmul_arb_if #(
  parameter int word_width = 16
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [4*word_width-1:0] req0_op;
  logic [4*word_width-1:0] req1_op;
  logic [1:0]              rsp_valid;
  logic [1:0]              rsp_ready;
  logic [word_width-1:0]   rsp_re;
  logic [word_width-1:0]   rsp_im;

  modport master (
    output req_valid, req0_op, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_re, rsp_im
  );

  modport slave (
    input  req_valid, req0_op, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_re, rsp_im
  );
endinterface

// File: rtl/bel_cmul_arb.sv
// rtl/bel_cmul_arb.sv - round-robin arbiter sharing one bel_cmul between two requesters
//
// Purpose: grants one of two requesters per cycle, muxes its operands into the
// shared multiplier, tracks each operation through the fixed multiplier
// latency with a valid/tag shift register and routes the product back to the
// issuing requester. A result that its owner cannot take halts the whole
// shared pipeline (multiplier included) through cm_halt_o.
// Ports:
//   clk_i, rst_n_i     clock (rising edge), asynchronous active-low reset
//   arb_if             requester/response handshakes (slave modport)
//   cm_a_*_o, cm_b_*_o operands to the multiplier
//   cm_halt_o          multiplier pipe_halt
//   cm_x_re_i/im_i     multiplier result
//   busy_o             any operation in flight
module bel_cmul_arb #(
  parameter int word_width = 16,
  parameter int cmul_lat   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  bel_cmul_arb_if.slave         arb_if,
  output logic [word_width-1:0] cm_a_re_o,
  output logic [word_width-1:0] cm_a_im_o,
  output logic [word_width-1:0] cm_b_re_o,
  output logic [word_width-1:0] cm_b_im_o,
  output logic                  cm_halt_o,
  input  logic [word_width-1:0] cm_x_re_i,
  input  logic [word_width-1:0] cm_x_im_i,
  output logic                  busy_o
);

  logic [cmul_lat:1]       v_q;
  logic [cmul_lat:1]       tag_q;
  logic                    ptr_q;
  logic                    halt;
  logic                    contested;
  logic                    gnt_idx;
  logic [1:0]              grant;
  logic [4*word_width-1:0] op_sel;

  // The head result stalls everything only when its own requester refuses it.
  assign halt      = v_q[cmul_lat] & ~arb_if.rsp_ready[tag_q[cmul_lat]];
  assign cm_halt_o = halt;

  // Gating with rst_n_i keeps req_ready low for the whole reset period.
  assign contested = rst_n_i & ~halt & (&arb_if.req_valid);

  always_comb begin
    grant   = 2'b00;
    gnt_idx = 1'b0;
    if (rst_n_i && !halt) begin
      if (arb_if.req_valid == 2'b11) begin
        gnt_idx = ptr_q;
        grant   = ptr_q ? 2'b10 : 2'b01;
      end else if (arb_if.req_valid[0]) begin
        gnt_idx = 1'b0;
        grant   = 2'b01;
      end else if (arb_if.req_valid[1]) begin
        gnt_idx = 1'b1;
        grant   = 2'b10;
      end
    end
  end

  assign arb_if.req_ready = grant;

  // Idle cycles feed zeros so the multiplier output never carries stale data.
  always_comb begin
    op_sel = '0;
    if (grant[1]) begin
      op_sel = arb_if.req1_op;
    end else if (grant[0]) begin
      op_sel = arb_if.req0_op;
    end
  end

  assign cm_a_re_o = op_sel[4*word_width-1 -: word_width];
  assign cm_a_im_o = op_sel[3*word_width-1 -: word_width];
  assign cm_b_re_o = op_sel[2*word_width-1 -: word_width];
  assign cm_b_im_o = op_sel[1*word_width-1 -: word_width];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q   <= '0;
      tag_q <= '0;
      ptr_q <= 1'b0;
    end else if (!halt) begin
      v_q[1]   <= |grant;
      tag_q[1] <= gnt_idx;
      for (int k = 2; k <= cmul_lat; k++) begin
        v_q[k]   <= v_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
      // Only a contested grant moves the pointer, to the loser.
      if (contested) begin
        ptr_q <= ~gnt_idx;
      end
    end
  end

  assign arb_if.rsp_valid = {v_q[cmul_lat] &  tag_q[cmul_lat],
                             v_q[cmul_lat] & ~tag_q[cmul_lat]};
  assign arb_if.rsp_re    = cm_x_re_i;
  assign arb_if.rsp_im    = cm_x_im_i;
  assign busy_o           = |v_q;

endmodule

// File: tb/tb_bel_cmul_arb.sv
// tb/tb_bel_cmul_arb.sv - directed self-checking bench for bel_cmul_arb
module tb_bel_cmul_arb;

  logic        clk_i;
  logic        rst_n_i;
  logic [15:0] cm_a_re, cm_a_im, cm_b_re, cm_b_im;
  logic        cm_halt;
  logic [15:0] cm_x_re, cm_x_im;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  bel_cmul_arb_if #(.word_width(16)) arb_if ();

  bel_cmul_arb #(.word_width(16), .cmul_lat(2)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .arb_if    (arb_if),
    .cm_a_re_o (cm_a_re),
    .cm_a_im_o (cm_a_im),
    .cm_b_re_o (cm_b_re),
    .cm_b_im_o (cm_b_im),
    .cm_halt_o (cm_halt),
    .cm_x_re_i (cm_x_re),
    .cm_x_im_i (cm_x_im),
    .busy_o    (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Two-stage Q1.15 complex multiplier stand-in with truncation and wrap.
  logic signed [15:0] ar, ai, br, bi;
  logic signed [32:0] pr, pi;
  logic [15:0] m1_re, m1_im, m2_re, m2_im;
  assign ar = cm_a_re;
  assign ai = cm_a_im;
  assign br = cm_b_re;
  assign bi = cm_b_im;
  assign pr = ar * br - ai * bi;
  assign pi = ar * bi + ai * br;
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m1_re <= '0; m1_im <= '0; m2_re <= '0; m2_im <= '0;
    end else if (!cm_halt) begin
      m1_re <= pr[30:15];
      m1_im <= pi[30:15];
      m2_re <= m1_re;
      m2_im <= m1_im;
    end
  end
  assign cm_x_re = m2_re;
  assign cm_x_im = m2_im;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_op(input logic [15:0] a_re, input logic [15:0] a_im,
                                        input logic [15:0] b_re, input logic [15:0] b_im);
    return {a_re, a_im, b_re, b_im};
  endfunction

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [1:0]  seen;
  logic [1:0]  exp_rv [4];
  logic [15:0] exp_re [4];

  initial begin
    rst_n_i          = 1'b0;
    arb_if.req_valid = 2'b11;
    arb_if.req0_op   = mk_op(16'h4000, 16'h0000, 16'h4000, 16'h0000);
    arb_if.req1_op   = '0;
    arb_if.rsp_ready = 2'b11;
    repeat (2) @(posedge clk_i);
    smp();
    check("rst_req_ready", arb_if.req_ready, 2'b00);
    check("rst_rsp_valid", arb_if.rsp_valid, 2'b00);
    check("rst_halt", cm_halt, 1'b0);
    check("rst_busy", busy, 1'b0);
    arb_if.req_valid = 2'b00;
    cyc();
    rst_n_i = 1'b1;

    // 1: single op from req0, 0.5 * 0.5 = 0.25
    arb_if.req_valid = 2'b01;
    smp();
    check("t1_ready", arb_if.req_ready, 2'b01);
    check("t1_cm_a_re", cm_a_re, 16'h4000);
    cyc();
    arb_if.req_valid = 2'b00;
    smp();
    check("t1_cm_idle", {cm_a_re, cm_a_im, cm_b_re, cm_b_im}, 64'h0);
    check("t1_rv_early", arb_if.rsp_valid, 2'b00);
    check("t1_busy", busy, 1'b1);
    cyc();
    smp();
    check("t1_rv", arb_if.rsp_valid, 2'b01);
    check("t1_re", arb_if.rsp_re, 16'h2000);
    check("t1_im", arb_if.rsp_im, 16'h0000);
    cyc();
    smp();
    check("t1_idle", busy, 1'b0);
    cyc();

    // 2: both valid for 4 cycles; alternating grants, results in order
    arb_if.req0_op = mk_op(16'h4000, 16'h0000, 16'h2000, 16'h0000);
    arb_if.req1_op = mk_op(16'h0000, 16'h4000, 16'h0000, 16'h4000);
    exp_rv = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_re = '{16'h1000, 16'hE000, 16'h1000, 16'hE000};
    for (int i = 0; i < 6; i++) begin
      arb_if.req_valid = (i < 4) ? 2'b11 : 2'b00;
      smp();
      if (i < 4) check($sformatf("t2_ready_%0d", i), arb_if.req_ready, exp_rv[i]);
      if (i >= 2) begin
        check($sformatf("t2_rv_%0d", i), arb_if.rsp_valid, exp_rv[i-2]);
        check($sformatf("t2_re_%0d", i), arb_if.rsp_re, exp_re[i-2]);
      end
      cyc();
    end
    smp();
    check("t2_idle", busy, 1'b0);
    cyc();

    // 3: head result refused for 3 cycles
    arb_if.req0_op   = mk_op(16'h4000, 16'h0000, 16'h4000, 16'h0000);
    arb_if.rsp_ready = 2'b00;
    arb_if.req_valid = 2'b01;
    smp();
    check("t3_ready0", arb_if.req_ready, 2'b01);
    cyc();
    arb_if.req_valid = 2'b10;
    smp();
    check("t3_ready1", arb_if.req_ready, 2'b10);
    cyc();
    arb_if.req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      smp();
      check($sformatf("t3_halt_%0d", i), cm_halt, 1'b1);
      check($sformatf("t3_ready_%0d", i), arb_if.req_ready, 2'b00);
      check($sformatf("t3_rv_%0d", i), arb_if.rsp_valid, 2'b01);
      check($sformatf("t3_re_%0d", i), arb_if.rsp_re, 16'h2000);
      cyc();
    end
    arb_if.rsp_ready = 2'b11;
    smp();
    check("t3_rel_halt", cm_halt, 1'b0);
    check("t3_rel_rv", arb_if.rsp_valid, 2'b01);
    check("t3_rel_re", arb_if.rsp_re, 16'h2000);
    check("t3_rel_ready", arb_if.req_ready, 2'b01);
    cyc();
    arb_if.req_valid = 2'b00;
    smp();
    check("t3_next_rv", arb_if.rsp_valid, 2'b10);
    check("t3_next_re", arb_if.rsp_re, 16'hE000);
    cyc();
    smp();
    check("t3_last_rv", arb_if.rsp_valid, 2'b01);
    check("t3_last_re", arb_if.rsp_re, 16'h2000);
    cyc();
    smp();
    check("t3_drained_rv", arb_if.rsp_valid, 2'b00);
    check("t3_drained_busy", busy, 1'b0);
    cyc();

    // 4: req1 alone, then one contested cycle shows the pointer did not move
    for (int i = 0; i < 8; i++) begin
      arb_if.req_valid = (i < 4) ? 2'b10 : (i == 4) ? 2'b11 : 2'b00;
      smp();
      if (i < 4)  check($sformatf("t4_ready_%0d", i), arb_if.req_ready, 2'b10);
      if (i == 4) check("t4_contested", arb_if.req_ready, 2'b01);
      if (i >= 2 && i <= 5) check($sformatf("t4_rv_%0d", i), arb_if.rsp_valid, 2'b10);
      if (i == 6) check("t4_rv_req0", arb_if.rsp_valid, 2'b01);
      if (i == 7) check("t4_idle", busy, 1'b0);
      cyc();
    end

    // 5: asynchronous reset with two operations in flight
    arb_if.req_valid = 2'b01;
    cyc();
    arb_if.req_valid = 2'b10;
    cyc();
    arb_if.req_valid = 2'b00;
    #2;
    rst_n_i = 1'b0;
    #1;
    check("t5_rv_async", arb_if.rsp_valid, 2'b00);
    check("t5_busy_async", busy, 1'b0);
    cyc();
    cyc();
    rst_n_i = 1'b1;
    seen = 2'b00;
    for (int i = 0; i < 4; i++) begin
      smp();
      seen = seen | arb_if.rsp_valid;
      cyc();
    end
    check("t5_no_result", seen, 2'b00);
    arb_if.req_valid = 2'b11;
    smp();
    check("t5_ptr_reset", arb_if.req_ready, 2'b01);
    cyc();
    arb_if.req_valid = 2'b00;
    repeat (3) cyc();

    // 6: -1 * -1 wraps to 0x8000, routed to requester 1
    arb_if.req1_op   = mk_op(16'h8000, 16'h0000, 16'h8000, 16'h0000);
    arb_if.req_valid = 2'b10;
    smp();
    check("t6_ready", arb_if.req_ready, 2'b10);
    check("t6_cm_a_re", cm_a_re, 16'h8000);
    cyc();
    arb_if.req_valid = 2'b00;
    smp();
    cyc();
    smp();
    check("t6_rv", arb_if.rsp_valid, 2'b10);
    check("t6_re", arb_if.rsp_re, 16'h8000);
    check("t6_im", arb_if.rsp_im, 16'h0000);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
